// File: rtl/ec_acc_pkg.sv
// Shared types and limits for the erasure-coding accelerator datapath blocks.
package ec_acc_pkg;

  localparam int MAX_LANES = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    OUT   = 2'd2,
    DONE  = 2'd3
  } stripe_seq_state_e;

endpackage

// File: rtl/stripe_rd_sequencer_lane_prio_pick.sv
// Lowest-index priority picker: one-hot grant of the least significant eligible lane.
module lane_prio_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0] req_i,
  output logic [N-1:0] grant_o,
  output logic         found_o
);

  // Two's-complement trick isolates the lowest set bit.
  assign grant_o = req_i & (~req_i + {{(N-1){1'b0}}, 1'b1});
  assign found_o = |req_i;

endmodule

// File: rtl/stripe_rd_sequencer.sv
// Read-side stripe scheduler: pulls one word per lane from the data FIFOs,
// assembles the stripe and presents it to the encoder over valid/ready.
module stripe_rd_sequencer
  import ec_acc_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int DATA_W    = 32,
  parameter int CNT_W     = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [CNT_W-1:0]            num_stripes,
  input  logic                        abort,
  output logic                        busy,
  output logic                        done,
  input  logic [NUM_LANES-1:0]        fifo_empty,
  output logic [NUM_LANES-1:0]        fifo_rd_req,
  input  logic [NUM_LANES-1:0]        fifo_rd_data_val,
  input  logic [NUM_LANES*DATA_W-1:0] fifo_rd_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NUM_LANES*DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]            out_stripe_idx,
  output logic                        err_unexp_val
);

  localparam int LW = NUM_LANES * DATA_W;

  stripe_seq_state_e state_q, state_d;

  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]     total_q, total_d;
  logic [CNT_W-1:0]     cnt_inc;
  logic [NUM_LANES-1:0] req_sent_q, req_sent_d;
  logic [NUM_LANES-1:0] got_q, got_d;
  logic [NUM_LANES-1:0] pend_q, pend_d;
  logic [NUM_LANES-1:0] rd_req_q, rd_req_d;
  logic [LW-1:0]        lane_q, lane_d;
  logic                 err_q, err_d;

  logic [NUM_LANES-1:0] elig;
  logic [NUM_LANES-1:0] pick_grant;
  logic                 pick_found;
  logic [NUM_LANES-1:0] cap;

  // pend_q tracks reads actually outstanding at the FIFO; it survives abort so
  // late data from a cancelled job is dropped quietly and never re-requested over.
  assign elig = (state_q == FETCH) ? (~req_sent_q & ~fifo_empty & ~pend_q) : '0;
  assign cap  = (state_q == FETCH) ? (fifo_rd_data_val & pend_q & req_sent_q & ~got_q) : '0;
  assign cnt_inc = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

  lane_prio_pick #(
    .N (NUM_LANES)
  ) u_pick (
    .req_i   (elig),
    .grant_o (pick_grant),
    .found_o (pick_found)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    total_d    = total_q;
    req_sent_d = req_sent_q;
    got_d      = got_q;
    pend_d     = pend_q & ~fifo_rd_data_val;
    rd_req_d   = '0;
    lane_d     = lane_q;
    err_d      = err_q | (|(fifo_rd_data_val & ~pend_q));

    for (int l = 0; l < NUM_LANES; l++) begin
      if (cap[l]) begin
        lane_d[l*DATA_W +: DATA_W] = fifo_rd_data[l*DATA_W +: DATA_W];
      end
    end

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          total_d    = num_stripes;
          cnt_d      = '0;
          err_d      = 1'b0;
          req_sent_d = '0;
          got_d      = '0;
          state_d    = (num_stripes == '0) ? DONE : FETCH;
        end
      end
      FETCH: begin
        got_d = got_q | cap;
        if (pick_found) begin
          rd_req_d   = pick_grant;
          req_sent_d = req_sent_q | pick_grant;
          pend_d     = pend_d | pick_grant;
        end
        if (&got_d) begin
          state_d = OUT;
        end
      end
      OUT: begin
        if (out_ready) begin
          cnt_d      = cnt_inc;
          req_sent_d = '0;
          got_d      = '0;
          state_d    = (cnt_inc == total_q) ? DONE : FETCH;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (abort) begin
      state_d    = IDLE;
      req_sent_d = '0;
      got_d      = '0;
      rd_req_d   = '0;
      pend_d     = pend_q & ~fifo_rd_data_val;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      total_q    <= '0;
      req_sent_q <= '0;
      got_q      <= '0;
      pend_q     <= '0;
      rd_req_q   <= '0;
      lane_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      total_q    <= total_d;
      req_sent_q <= req_sent_d;
      got_q      <= got_d;
      pend_q     <= pend_d;
      rd_req_q   <= rd_req_d;
      lane_q     <= lane_d;
      err_q      <= err_d;
    end
  end

  assign busy           = (state_q != IDLE);
  assign done           = (state_q == DONE);
  assign out_valid      = (state_q == OUT);
  assign fifo_rd_req    = rd_req_q;
  assign out_data       = lane_q;
  assign out_stripe_idx = cnt_q;
  assign err_unexp_val  = err_q;

endmodule
